// File: rtl/uart_tx_word.sv
// UART transmitter sending one or two bytes per accepted 16-bit word.
// Each byte is framed as start, 8 data bits LSB first, and stop. The line idles high.
module uart_tx_word #(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned WORD_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] tx_data,
  input  logic        tx_data_valid,
  output logic        tx_data_ready,
  output logic        tx_pin
);

  localparam int unsigned CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] LAST_CNT = 16'(CYCLE - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_SEND_BYTE = 2'd2;
  localparam logic [1:0] S_STOP      = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [15:0] r_cycle_cnt;
  logic [2:0]  r_bit_cnt;
  logic        r_byte_idx;
  logic [15:0] r_data;
  logic        r_ready;
  logic        r_pin;
  logic        w_bit_end;
  logic        w_accept;
  logic        w_more_bytes;
  logic [7:0]  w_cur_byte;

  assign w_bit_end     = (r_cycle_cnt == LAST_CNT);
  assign w_accept      = tx_data_valid && r_ready;
  assign w_more_bytes  = (WORD_BYTES == 2) && !r_byte_idx;
  assign w_cur_byte    = r_byte_idx ? r_data[15:8] : r_data[7:0];
  assign tx_data_ready = r_ready;
  assign tx_pin        = r_pin;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next_state = S_START;
      S_START:     if (w_bit_end) w_next_state = S_SEND_BYTE;
      S_SEND_BYTE: if (w_bit_end && r_bit_cnt == 3'd7) w_next_state = S_STOP;
      S_STOP:      if (w_bit_end) w_next_state = w_more_bytes ? S_START : S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Ready is derived from the next state so it is high exactly while the state is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_cycle_cnt <= '0;
      r_bit_cnt   <= '0;
      r_byte_idx  <= 1'b0;
      r_data      <= '0;
      r_pin       <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == S_IDLE);

      if (w_next_state != r_state || r_state == S_IDLE || w_bit_end)
        r_cycle_cnt <= '0;
      else
        r_cycle_cnt <= r_cycle_cnt + 16'd1;

      if (r_state != S_SEND_BYTE)
        r_bit_cnt <= '0;
      else if (w_bit_end)
        r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_accept) begin
        r_data     <= tx_data;
        r_byte_idx <= 1'b0;
      end else if (r_state == S_STOP && w_bit_end && w_more_bytes) begin
        r_byte_idx <= 1'b1;
      end

      // The pin follows the state one clock later.
      case (r_state)
        S_START:     r_pin <= 1'b0;
        S_SEND_BYTE: r_pin <= w_cur_byte[r_bit_cnt];
        default:     r_pin <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_word.sv
// Directed bench for uart_tx_word: two-byte, one-byte and default-rate instances.
// The serial line is checked on every clock against hand-derived bit patterns.
module tb_uart_tx_word;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx_data = '0;
  logic        v2 = 1'b0;
  logic        v1 = 1'b0;
  logic        vd = 1'b0;
  logic        rdy2, pin2, rdy1, pin1, rdyd, pind;
  logic        sel = 1'b0;
  logic        w_pin, w_rdy;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign w_pin = sel ? pin1 : pin2;
  assign w_rdy = sel ? rdy1 : rdy2;

  uart_tx_word #(.CLK_FRE(1), .BAUD_RATE(100000), .WORD_BYTES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_data_valid(v2),
    .tx_data_ready(rdy2), .tx_pin(pin2));

  uart_tx_word #(.CLK_FRE(1), .BAUD_RATE(100000), .WORD_BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_data_valid(v1),
    .tx_data_ready(rdy1), .tx_pin(pin1));

  uart_tx_word dutd (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_data_valid(vd),
    .tx_data_ready(rdyd), .tx_pin(pind));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks one 10-bit frame (CYCLE=10) on the selected instance, one comparison per clock.
  // Ready is expected high only on the final clock of the last byte of a word.
  task automatic frame(input logic [7:0] b, input bit last, input int unsigned chg, input string tag);
    logic exp_pin;
    logic exp_rdy;
    for (int unsigned i = 0; i < 10; i++) begin
      for (int unsigned j = 0; j < 10; j++) begin
        if (i == 0)      exp_pin = 1'b0;
        else if (i == 9) exp_pin = 1'b1;
        else             exp_pin = b[i-1];
        exp_rdy = last && (i == 9) && (j == 9);
        check($sformatf("%s_pin_b%0d_c%0d", tag, i, j), 16'(w_pin), 16'(exp_pin));
        check($sformatf("%s_rdy_b%0d_c%0d", tag, i, j), 16'(w_rdy), 16'(exp_rdy));
        if (chg != 0 && (i * 10 + j + 1) == chg) tx_data = 16'hFFFF;
        tick();
      end
    end
  endtask

  initial begin
    int n;

    // Reset holds everything quiet even with valid asserted.
    rst_n = 1'b0;
    v2 = 1'b1;
    tick(); tick(); tick();
    check("rst_pin2", 16'(pin2), 16'd1);
    check("rst_rdy2", 16'(rdy2), 16'd0);
    check("rst_pin1", 16'(pin1), 16'd1);
    check("rst_rdy1", 16'(rdy1), 16'd0);
    check("rst_pind", 16'(pind), 16'd1);
    check("rst_rdyd", 16'(rdyd), 16'd0);
    rst_n = 1'b1;
    tick();
    check("rel_rdy2", 16'(rdy2), 16'd1);
    check("rel_rdy1", 16'(rdy1), 16'd1);
    check("rel_rdyd", 16'(rdyd), 16'd1);
    v2 = 1'b0;
    tick();
    check("noacc_rdy2", 16'(rdy2), 16'd1);
    check("noacc_pin2", 16'(pin2), 16'd1);

    // Single word 0xA55A: 0x5A then 0xA5, 200 clocks.
    sel = 1'b0;
    tx_data = 16'hA55A;
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    check("w1_acc_rdy", 16'(rdy2), 16'd0);
    check("w1_acc_pin", 16'(pin2), 16'd1);
    tick();
    frame(8'h5A, 1'b0, 0, "w1_lo");
    frame(8'hA5, 1'b1, 0, "w1_hi");
    check("w1_end_pin", 16'(pin2), 16'd1);
    check("w1_end_rdy", 16'(rdy2), 16'd1);

    // Single-byte instance sends only the low byte.
    sel = 1'b1;
    tx_data = 16'h1234;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check("sb_acc_rdy", 16'(rdy1), 16'd0);
    check("sb_acc_pin", 16'(pin1), 16'd1);
    tick();
    frame(8'h34, 1'b1, 0, "sb");
    check("sb_end_pin", 16'(pin1), 16'd1);
    check("sb_end_rdy", 16'(rdy1), 16'd1);
    tick();
    check("sb_idle_pin", 16'(pin1), 16'd1);

    // Back-to-back words with valid held: one extra high clock between words.
    sel = 1'b0;
    tx_data = 16'h00FF;
    v2 = 1'b1;
    tick();
    check("bb_acc1_rdy", 16'(rdy2), 16'd0);
    tx_data = 16'hFF00;
    tick();
    frame(8'hFF, 1'b0, 0, "bb_w1_lo");
    frame(8'h00, 1'b1, 0, "bb_w1_hi");
    check("bb_gap_pin", 16'(pin2), 16'd1);
    check("bb_gap_rdy", 16'(rdy2), 16'd0);
    v2 = 1'b0;
    tick();
    frame(8'h00, 1'b0, 0, "bb_w2_lo");
    frame(8'hFF, 1'b1, 0, "bb_w2_hi");
    check("bb_end_pin", 16'(pin2), 16'd1);
    check("bb_end_rdy", 16'(rdy2), 16'd1);

    // Input data changed at clock 35 of the frame must not leak into it.
    tx_data = 16'h0F0F;
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    tick();
    frame(8'h0F, 1'b0, 35, "chg_lo");
    frame(8'h0F, 1'b1, 0, "chg_hi");
    check("chg_end_rdy", 16'(rdy2), 16'd1);

    // Reset at clock 50 of a frame aborts it.
    tx_data = 16'hA55A;
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    tick();
    check("mr_start_pin", 16'(pin2), 16'd0);
    repeat (49) tick();
    rst_n = 1'b0;
    tick();
    check("mr_rst_pin", 16'(pin2), 16'd1);
    check("mr_rst_rdy", 16'(rdy2), 16'd0);
    rst_n = 1'b1;
    tick();
    check("mr_rel_rdy", 16'(rdy2), 16'd1);
    check("mr_rel_pin", 16'(pin2), 16'd1);
    tx_data = 16'h3C96;
    v2 = 1'b1;
    tick();
    v2 = 1'b0;
    tick();
    frame(8'h96, 1'b0, 0, "mr_lo");
    frame(8'h3C, 1'b1, 0, "mr_hi");
    check("mr_end_pin", 16'(pin2), 16'd1);

    // Default parameters: 50 MHz / 115200 gives 434 clocks per bit.
    tx_data = 16'h0055;
    vd = 1'b1;
    tick();
    vd = 1'b0;
    tick();
    check("def_start_pin", 16'(pind), 16'd0);
    n = 0;
    while (pind === 1'b0 && n < 1000) begin
      tick();
      n++;
    end
    check("def_start_len", 16'(n), 16'd434);
    n = 0;
    while (pind === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check("def_bit0_len", 16'(n), 16'd434);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
